// File: rtl/buffer_memory_pkg.sv
// buffer_memory_pkg: shared widths, defaults and clog2 for the buffer memory family.
package buffer_memory_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int DATA_WIDTH_DEF = 40;
  localparam int DATA_DEPTH_DEF = 16;
  localparam int NUM_CHANNELS_DEF = 4;
  localparam int CH_WIDTH = clog2(NUM_CHANNELS_DEF);
  localparam int PTR_WIDTH = clog2(DATA_DEPTH_DEF);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
endpackage

// File: rtl/buffer_memory_mc_rr_arbiter.sv
// rr_arbiter: round-robin grant, search starts at last+1 and wraps modulo N.
module rr_arbiter
  import buffer_memory_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2(N)
)(
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic         en,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);
  always_comb begin
    gnt_idx = last;
    for (int i = N; i >= 1; i--)
      if (req[(int'(last) + i) % N]) gnt_idx = W'((int'(last) + i) % N);
  end
  assign gnt_valid = en && |req;
endmodule

// File: rtl/buffer_memory_mc.sv
// buffer_memory_mc: NUM_CHANNELS FIFOs in one shared array, round-robin drained to one registered port.
// Optional sticky error outputs overflow_err/chan_err under BUFFER_MEMORY_MC_ERR_EN.
module buffer_memory_mc
  import buffer_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF,
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int AFULL_LEVEL = 12,
  localparam int CH_W = clog2(NUM_CHANNELS),
  localparam int PTR_W = clog2(DATA_DEPTH),
  localparam int CNT_W = PTR_W + 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [CH_W-1:0]         in_channel,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    ready,
  output logic                    out_valid,
  output logic [CH_W-1:0]         out_channel,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    next_ready,
  output logic [NUM_CHANNELS-1:0] empty,
  output logic [NUM_CHANNELS-1:0] full,
`ifdef BUFFER_MEMORY_MC_ERR_EN
  output logic [NUM_CHANNELS-1:0] almost_full,
  output logic [NUM_CHANNELS-1:0] overflow_err,
  output logic                    chan_err
`else
  output logic [NUM_CHANNELS-1:0] almost_full
`endif
);
  logic [DATA_WIDTH-1:0] mem [NUM_CHANNELS*DATA_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CHANNELS];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CHANNELS];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CHANNELS];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_q [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_d [NUM_CHANNELS];
  logic out_valid_q, out_valid_d;
  logic [CH_W-1:0] out_channel_q, out_channel_d, last_q, last_d, gnt_idx;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, head;
  logic ch_ok, wr, load, gnt_valid;
  assign ch_ok = {1'b0, in_channel} < (CH_W+1)'(NUM_CHANNELS);
  assign ready = ch_ok && !full[in_channel];
  assign wr = in_valid && ready;
  assign load = !out_valid_q || next_ready;
  assign head = mem[{gnt_idx, rd_ptr_q[gnt_idx]}];
  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req(~empty), .last(last_q), .en(load), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
  );
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_flags
    assign empty[g] = cnt_q[g] == '0;
    assign full[g] = cnt_q[g] == CNT_W'(DATA_DEPTH);
    assign almost_full[g] = cnt_q[g] >= CNT_W'(AFULL_LEVEL);
  end
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d = cnt_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(wr && in_channel == CH_W'(c));
      rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(gnt_valid && gnt_idx == CH_W'(c));
      cnt_d[c] = cnt_q[c] + CNT_W'(wr && in_channel == CH_W'(c)) - CNT_W'(gnt_valid && gnt_idx == CH_W'(c));
    end
    out_valid_d = load ? gnt_valid : out_valid_q;
    out_data_d = gnt_valid ? head : out_data_q;
    out_channel_d = gnt_valid ? gnt_idx : out_channel_q;
    last_d = gnt_valid ? gnt_idx : last_q;
  end
  // Storage is intentionally left unreset; counts alone define validity.
  always_ff @(posedge clk)
    if (wr) mem[{in_channel, wr_ptr_q[in_channel]}] <= in_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_channel_q <= '0;
      last_q <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_channel_q <= out_channel_d;
      last_q <= last_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_channel = out_channel_q;
`ifdef BUFFER_MEMORY_MC_ERR_EN
  logic [NUM_CHANNELS-1:0] overflow_err_q;
  logic chan_err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_err_q <= '0;
      chan_err_q <= 1'b0;
    end else begin
      overflow_err_q <= overflow_err_q | ({NUM_CHANNELS{in_valid && ch_ok}} & full & (NUM_CHANNELS'(1) << in_channel));
      chan_err_q <= chan_err_q | (in_valid && !ch_ok);
    end
  end
  assign overflow_err = overflow_err_q;
  assign chan_err = chan_err_q;
`endif
endmodule

// File: tb/tb_buffer_memory_mc.sv
// tb_buffer_memory_mc: directed self-checking bench for buffer_memory_mc (default 40x16x4 configuration).
module tb_buffer_memory_mc;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, next_ready = 1'b0;
  logic [1:0] in_channel = '0;
  logic [39:0] in_data = '0;
  logic ready, out_valid;
  logic [1:0] out_channel;
  logic [39:0] out_data;
  logic [3:0] empty, full, almost_full;
`ifdef BUFFER_MEMORY_MC_ERR_EN
  logic [3:0] overflow_err;
  logic chan_err;
`endif
  int n_checks = 0, n_fail = 0;
  logic [39:0] sd [6] = '{40'h301, 40'h200, 40'h302, 40'h303, 40'h305, 40'h304};
  logic [1:0]  sc [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
  buffer_memory_mc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
    .ready(ready), .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
    .next_ready(next_ready), .empty(empty), .full(full),
`ifdef BUFFER_MEMORY_MC_ERR_EN
    .almost_full(almost_full), .overflow_err(overflow_err), .chan_err(chan_err)
`else
    .almost_full(almost_full)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] ch, input logic [39:0] d);
    in_valid = 1'b1;
    in_channel = ch;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_empty", empty, 4'hF);
    check("rst_full", full, 4'h0);
    check("rst_afull", almost_full, 4'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 40'h0);
    check("rst_chan", out_channel, 2'd0);
    check("rst_ready", ready, 1'b1);
    next_ready = 1'b1;
    wr(2'd2, 40'h5);
    check("single_empty_after_wr", empty, 4'b1011);
    check("single_valid_early", out_valid, 1'b0);
    tick();
    check("single_valid", out_valid, 1'b1);
    check("single_chan", out_channel, 2'd2);
    check("single_data", out_data, 40'h5);
    check("single_empty", empty, 4'hF);
    tick();
    check("single_drained", out_valid, 1'b0);
    check("single_data_hold", out_data, 40'h5);
    next_ready = 1'b0;
    wr(2'd0, 40'hA1);
    check("rr_pre_valid", out_valid, 1'b0);
    wr(2'd0, 40'hA2);
    wr(2'd1, 40'hB1);
    wr(2'd3, 40'hD1);
    check("rr_held_data", out_data, 40'hA1);
    check("rr_held_chan", out_channel, 2'd0);
    next_ready = 1'b1;
    tick();
    check("rr_1_data", out_data, 40'hB1);
    check("rr_1_chan", out_channel, 2'd1);
    tick();
    check("rr_2_data", out_data, 40'hD1);
    check("rr_2_chan", out_channel, 2'd3);
    tick();
    check("rr_3_data", out_data, 40'hA2);
    check("rr_3_chan", out_channel, 2'd0);
    tick();
    check("rr_end_valid", out_valid, 1'b0);
    next_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      wr(2'd1, 40'(i));
      if (i == 12) check("fill_afull_12", almost_full[1], 1'b0);
      if (i == 13) check("fill_afull_13", almost_full[1], 1'b1);
      if (i == 16) check("fill_full_16", full[1], 1'b0);
    end
    check("fill_full_17", full[1], 1'b1);
    check("fill_ready_17", ready, 1'b0);
    check("fill_out_data", out_data, 40'h1);
    wr(2'd1, 40'h99);
    check("fill_drop_full", full, 4'b0010);
    check("fill_drop_out", out_data, 40'h1);
    next_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      check("drain_valid", out_valid, 1'b1);
      check("drain_data", out_data, 40'(i));
      tick();
    end
    check("drain_end_valid", out_valid, 1'b0);
    check("drain_end_empty", empty, 4'hF);
    next_ready = 1'b0;
    wr(2'd0, 40'h100);
    check("stall_pre_valid", out_valid, 1'b0);
    wr(2'd2, 40'h200);
    wr(2'd1, 40'h301);
    check("stall_data_1", out_data, 40'h100);
    wr(2'd3, 40'h302);
    wr(2'd1, 40'h303);
    check("stall_data_3", out_data, 40'h100);
    wr(2'd3, 40'h304);
    wr(2'd2, 40'h305);
    check("stall_data_5", out_data, 40'h100);
    check("stall_chan_5", out_channel, 2'd0);
    check("stall_valid_5", out_valid, 1'b1);
    next_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_drain_data", out_data, sd[i]);
      check("stall_drain_chan", out_channel, sc[i]);
    end
    tick();
    check("stall_end_valid", out_valid, 1'b0);
`ifdef BUFFER_MEMORY_MC_ERR_EN
    next_ready = 1'b0;
    for (int i = 1; i <= 17; i++) wr(2'd3, 40'(i));
    check("err_pre_ovf", overflow_err, 4'h0);
    wr(2'd3, 40'hEE);
    check("err_ovf_set", overflow_err, 4'b1000);
    check("err_chan", chan_err, 1'b0);
    next_ready = 1'b1;
    repeat (18) tick();
    check("err_drained", empty, 4'hF);
    check("err_ovf_sticky", overflow_err, 4'b1000);
`endif
    next_ready = 1'b0;
    wr(2'd0, 40'hAA);
    wr(2'd0, 40'hBB);
    check("arst_pre_valid", out_valid, 1'b1);
    check("arst_pre_empty", empty, 4'b1110);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, 40'h0);
    check("arst_chan", out_channel, 2'd0);
    check("arst_empty", empty, 4'hF);
`ifdef BUFFER_MEMORY_MC_ERR_EN
    check("arst_ovf", overflow_err, 4'h0);
`endif
    #1;
    reset = 1'b0;
    tick();
    check("arst_post_valid", out_valid, 1'b0);
    check("arst_post_empty", empty, 4'hF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buffer_memory_mc.md
# buffer_memory_mc

Multi-channel successor to the single-queue buffer memory. It holds NUM_CHANNELS independent FIFO queues in one shared storage array and accepts writes tagged with a channel index. A round-robin arbiter drains all non-empty channels into one registered output port, which uses the same `next_ready` back-pressure as the single-queue block. It sits between multi-source producers and a single downstream consumer.

## Interface
- DATA_WIDTH, 40, word width
- DATA_DEPTH, 16, entries per channel; power of two, ≥2
- NUM_CHANNELS, 4, number of queues; ≥2
- AFULL_LEVEL, 12, per-channel storage count at which almost_full asserts; 1..DATA_DEPTH
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  write request
- in_channel  in  CH_WIDTH=clog2(NUM_CHANNELS)  target queue
- in_data  in  DATA_WIDTH  write word
- ready  out  1  combinational; `!full[in_channel]`; 0 if in_channel ≥ NUM_CHANNELS
- out_valid  out  1  output register holds a word
- out_channel  out  CH_WIDTH  source queue of out_data
- out_data  out  DATA_WIDTH  output word
- next_ready  in  1  consumer accepts out_data this cycle
- empty  out  NUM_CHANNELS  per-channel storage count == 0
- full  out  NUM_CHANNELS  per-channel storage count == DATA_DEPTH
- almost_full  out  NUM_CHANNELS  per-channel storage count ≥ AFULL_LEVEL

## Operation
- Storage is one array of NUM_CHANNELS*DATA_DEPTH words, addressed as channel*DATA_DEPTH + pointer.
- Each channel has a write pointer and a read pointer (clog2(DATA_DEPTH) bits, natural wrap) and a count (clog2(DATA_DEPTH)+1 bits).
- Write fires when in_valid && ready at a rising edge. The word is stored at wr_ptr[in_channel], which increments. in_valid while !ready is dropped with no state change.
- Load condition: `!out_valid || next_ready`. When it holds and any channel is non-empty, the arbiter grants one channel. The head word of that channel goes into out_data/out_channel, out_valid is set to 1, and that channel's rd_ptr increments.
- When the load condition holds and no channel is non-empty, out_valid clears; out_data and out_channel hold their values.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps modulo NUM_CHANNELS. last_grant updates only on a grant.
- A write and a pop on the same channel in the same edge are both performed and the count is unchanged. This also applies to a full channel when a pop frees a slot in that edge, but ready is computed from the pre-edge count, so the write is only accepted if ready was already high.
- Words in the output register are not counted in empty, full or almost_full.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all pointers and counts = 0; last_grant = NUM_CHANNELS-1, so channel 0 wins first
  - out_valid=0, out_data=0, out_channel=0
  - empty=all ones, full=0, almost_full=0
  - memory contents are not reset
  - reset mid-transfer discards all queued words and the held output word
- Latency from write to output: a write at edge k gives out_valid=1 after edge k+1, provided the output register is free and the channel wins arbitration.
- Flags update on the same edge as the count change.
- When out_valid=1 and next_ready=0, out_data and out_channel stay stable.
- Sustained throughput is one word per cycle on each side.

## Configuration
- BUFFER_MEMORY_MC_ERR_EN defined:
  - adds output overflow_err [NUM_CHANNELS], sticky, cleared only by reset
  - bit c sets on the edge where in_valid=1, in_channel=c and full[c]=1
  - adds output chan_err [1], sticky; sets when in_valid=1 and in_channel ≥ NUM_CHANNELS
- BUFFER_MEMORY_MC_ERR_EN undefined: neither port nor its logic exists; dropped writes are silent.

## Structure
- Package buffer_memory_pkg holds:
  - the clog2 function
  - derived widths CH_WIDTH, PTR_WIDTH, CNT_WIDTH
  - default DATA_WIDTH/DATA_DEPTH constants shared with the single-queue block
- Sub-module rr_arbiter (params N; inputs req[N], last[clog2 N], en; outputs gnt_valid, gnt_idx) holds the wrap-around priority search. Storage, pointers and the output register stay in the top module.

## Test plan
- Reset: hold reset=1, then release → empty=4'hF, full=0, out_valid=0, out_data=0. Assert reset asynchronously mid-cycle with data queued → outputs return to reset values before the next edge.
- Single word: write 40'h5 to ch2 at edge 0 with next_ready=1 → out_valid=1, out_channel=2, out_data=40'h5 after edge 1; empty[2]=1 again.
- Round-robin: with next_ready=0, preload ch0={A1,A2}, ch1={B1}, ch3={D1}; then set next_ready=1 → output order A1, B1, D1, A2, then out_valid=0.
- Fill/full: next_ready=0, write 40'h1..40'h11 to ch1 on consecutive edges →
  - 40'h1 is held in the output register
  - almost_full[1]=1 after the 13th write
  - full[1]=1 and ready=0 (in_channel=1) after the 17th write
  - an 18th write is dropped
  - draining returns 40'h1..40'h11 in order
- Stall: out_valid=1 with next_ready=0 for 5 cycles while other channels receive writes → out_data and out_channel unchanged, no word lost.
- BUFFER_MEMORY_MC_ERR_EN: write to a full ch3 → overflow_err[3]=1 after that edge, still 1 after draining, 0 after reset.
